lsb_embed: RTL and testbench

Steganographic embedding stage placed directly downstream of the pixel input FIFO. Pulls one RGB pixel (three bytes) per read handshake and writes LSB_BITS secret-message bits into the low bits of each channel. Message bits come MSB-first from a 32-bit word stream. Emits the 24-bit stego pixel on a valid/ready output. Once the message is exhausted, or when no message is armed, pixels pass through unmodified.

---
 rtl/lsb_embed.sv | 216 +++++++++++++++++++++
 tb/tb_lsb_embed.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_embed.sv
`default_nettype none
// ============================================================================
// Module   : lsb_embed
// Purpose  : Steganographic embedding stage. Reads one RGB pixel at a time
//            from the upstream pixel FIFO and replaces the LSB_BITS low bits
//            of each channel with message bits. Message bits are taken
//            MSB-first from a stream of MSG_WIDTH-bit words. When no message
//            is armed, or once it is exhausted, pixels pass through as they
//            are.
// Ports    : clk, rst (sync, active-low)
//            start/msg_len          - arm a message of msg_len bits
//            msg_word/msg_vld/msg_rdy - message word stream
//            pix_rd_req/pix_rd_vld  - FIFO read handshake
//            pix_r/pix_g/pix_b      - FIFO data, valid the cycle after the read
//            out_pix/out_vld/out_rdy - stego pixel {R,G,B} output
//            busy, done             - message armed / completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module lsb_embed #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MSG_WIDTH   = 32,
    parameter int LSB_BITS    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              msg_len,
    input  logic [MSG_WIDTH-1:0]     msg_word,
    input  logic                     msg_vld,
    output logic                     msg_rdy,
    output logic                     pix_rd_req,
    input  logic                     pix_rd_vld,
    input  logic [PIXEL_WIDTH-1:0]   pix_r,
    input  logic [PIXEL_WIDTH-1:0]   pix_g,
    input  logic [PIXEL_WIDTH-1:0]   pix_b,
    output logic [3*PIXEL_WIDTH-1:0] out_pix,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     busy,
    output logic                     done
);

    localparam int                 c_CNT_W    = $clog2(MSG_WIDTH + 1);
    // Rounds msg_len down to a multiple of LSB_BITS (LSB_BITS is 1 or 2).
    localparam logic [15:0]        c_LEN_MASK = ~16'(LSB_BITS - 1);
    localparam logic [15:0]        c_STEP_LEN = 16'(LSB_BITS);
    localparam logic [c_CNT_W-1:0] c_STEP_CNT = c_CNT_W'(LSB_BITS);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(MSG_WIDTH);

    typedef enum logic [2:0] {
        S_REQ = 3'd0,
        S_CAP = 3'd1,
        S_R   = 3'd2,
        S_G   = 3'd3,
        S_B   = 3'd4,
        S_OUT = 3'd5
    } state_t;

    state_t                 r_state_q,      w_state_d;
    logic [PIXEL_WIDTH-1:0] r_hold_r_q,     w_hold_r_d;
    logic [PIXEL_WIDTH-1:0] r_hold_g_q,     w_hold_g_d;
    logic [PIXEL_WIDTH-1:0] r_hold_b_q,     w_hold_b_d;
    logic [MSG_WIDTH-1:0]   r_buf_q,        w_buf_d;
    logic [c_CNT_W-1:0]     r_buf_cnt_q,    w_buf_cnt_d;
    logic [15:0]            r_bits_left_q,  w_bits_left_d;
    logic                   r_busy_q,       w_busy_d;
    logic                   r_done_q,       w_done_d;
    logic                   r_last_q,       w_last_d;
    logic                   r_pix_rd_req_q, w_pix_rd_req_d;
    logic                   r_msg_rdy_q,    w_msg_rdy_d;
    logic                   r_out_vld_q,    w_out_vld_d;

    logic                   w_active;
    logic [15:0]            w_eff_len;
    logic [PIXEL_WIDTH-1:0] w_chan;
    logic [PIXEL_WIDTH-1:0] w_chan_emb;

    // Channel currently being processed, and its embedded version.
    always_comb begin
        case (r_state_q)
            S_G:     w_chan = r_hold_g_q;
            S_B:     w_chan = r_hold_b_q;
            default: w_chan = r_hold_r_q;
        endcase
    end

    assign w_chan_emb = {w_chan[PIXEL_WIDTH-1:LSB_BITS], r_buf_q[MSG_WIDTH-1 -: LSB_BITS]};
    assign w_active   = (r_bits_left_q != '0);
    assign w_eff_len  = msg_len & c_LEN_MASK;

    always_comb begin
        w_state_d     = r_state_q;
        w_hold_r_d    = r_hold_r_q;
        w_hold_g_d    = r_hold_g_q;
        w_hold_b_d    = r_hold_b_q;
        w_buf_d       = r_buf_q;
        w_buf_cnt_d   = r_buf_cnt_q;
        w_bits_left_d = r_bits_left_q;
        w_busy_d      = r_busy_q;
        w_last_d      = r_last_q;
        w_done_d      = 1'b0;

        case (r_state_q)
            S_REQ: begin
                if (r_pix_rd_req_q && pix_rd_vld) begin
                    w_state_d = S_CAP;
                end
            end
            S_CAP: begin
                w_hold_r_d = pix_r;
                w_hold_g_d = pix_g;
                w_hold_b_d = pix_b;
                w_state_d  = S_R;
            end
            S_R, S_G, S_B: begin
                if (w_active && (r_buf_cnt_q == '0)) begin
                    // Buffer empty: wait here for the next word, one extra cycle.
                    if (r_msg_rdy_q && msg_vld) begin
                        w_buf_d     = msg_word;
                        w_buf_cnt_d = c_FULL_CNT;
                    end
                end else begin
                    if (w_active) begin
                        case (r_state_q)
                            S_R:     w_hold_r_d = w_chan_emb;
                            S_G:     w_hold_g_d = w_chan_emb;
                            default: w_hold_b_d = w_chan_emb;
                        endcase
                        w_buf_d       = r_buf_q << LSB_BITS;
                        w_buf_cnt_d   = r_buf_cnt_q - c_STEP_CNT;
                        w_bits_left_d = r_bits_left_q - c_STEP_LEN;
                        if (r_bits_left_q == c_STEP_LEN) begin
                            // Last bit goes into this pixel; drop any leftover bits.
                            w_last_d    = 1'b1;
                            w_buf_cnt_d = '0;
                        end
                    end
                    case (r_state_q)
                        S_R:     w_state_d = S_G;
                        S_G:     w_state_d = S_B;
                        default: w_state_d = S_OUT;
                    endcase
                end
            end
            S_OUT: begin
                if (out_rdy) begin
                    w_state_d = S_REQ;
                    if (r_last_q) begin
                        w_done_d = 1'b1;
                        w_busy_d = 1'b0;
                        w_last_d = 1'b0;
                    end
                end
            end
            default: w_state_d = S_REQ;
        endcase

        // Only idle blocks accept start; busy is 0 so bits_left is already 0.
        if (start && !r_busy_q) begin
            if (w_eff_len == '0) begin
                w_done_d = 1'b1;
            end else begin
                w_bits_left_d = w_eff_len;
                w_buf_cnt_d   = '0;
                w_busy_d      = 1'b1;
            end
        end

        // Outputs are registered from the next-cycle state so they line up with it.
        w_pix_rd_req_d = (w_state_d == S_REQ);
        w_out_vld_d    = (w_state_d == S_OUT);
        w_msg_rdy_d    = ((w_state_d == S_R) || (w_state_d == S_G) || (w_state_d == S_B)) &&
                         (w_bits_left_d != '0) && (w_buf_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q      <= S_REQ;
            r_hold_r_q     <= '0;
            r_hold_g_q     <= '0;
            r_hold_b_q     <= '0;
            r_buf_q        <= '0;
            r_buf_cnt_q    <= '0;
            r_bits_left_q  <= '0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_last_q       <= 1'b0;
            r_pix_rd_req_q <= 1'b0;
            r_msg_rdy_q    <= 1'b0;
            r_out_vld_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_hold_r_q     <= w_hold_r_d;
            r_hold_g_q     <= w_hold_g_d;
            r_hold_b_q     <= w_hold_b_d;
            r_buf_q        <= w_buf_d;
            r_buf_cnt_q    <= w_buf_cnt_d;
            r_bits_left_q  <= w_bits_left_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_last_q       <= w_last_d;
            r_pix_rd_req_q <= w_pix_rd_req_d;
            r_msg_rdy_q    <= w_msg_rdy_d;
            r_out_vld_q    <= w_out_vld_d;
        end
    end

    assign pix_rd_req = r_pix_rd_req_q;
    assign msg_rdy    = r_msg_rdy_q;
    assign out_vld    = r_out_vld_q;
    assign out_pix    = {r_hold_r_q, r_hold_g_q, r_hold_b_q};
    assign busy       = r_busy_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_embed.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsb_embed
// Purpose  : Directed bench for lsb_embed. Instance 0 uses LSB_BITS=1,
//            instance 1 uses LSB_BITS=2. Expected pixels are queued when a
//            pixel is fed and popped at the output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsb_embed;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start, msg_vld, msg_rdy, pix_rd_req, pix_rd_vld;
    logic [1:0]       out_vld, out_rdy, busy, done;
    logic [1:0][15:0] msg_len;
    logic [1:0][31:0] msg_word;
    logic [1:0][7:0]  pix_r, pix_g, pix_b;
    logic [1:0][23:0] out_pix;

    int               n_assert = 0;
    int               n_fail   = 0;
    int               done_cnt0 = 0;
    int               done_cnt1 = 0;
    int               stall_lat = 0;
    logic [23:0]      sb[$];
    logic [31:0]      wq[$];
    logic [63:0]      mbits;
    int               mp;

    always #5 clk = ~clk;

    lsb_embed #(.PIXEL_WIDTH(8), .MSG_WIDTH(32), .LSB_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .msg_len(msg_len[0]),
        .msg_word(msg_word[0]), .msg_vld(msg_vld[0]), .msg_rdy(msg_rdy[0]),
        .pix_rd_req(pix_rd_req[0]), .pix_rd_vld(pix_rd_vld[0]),
        .pix_r(pix_r[0]), .pix_g(pix_g[0]), .pix_b(pix_b[0]),
        .out_pix(out_pix[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]),
        .busy(busy[0]), .done(done[0])
    );

    lsb_embed #(.PIXEL_WIDTH(8), .MSG_WIDTH(32), .LSB_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[1]), .msg_len(msg_len[1]),
        .msg_word(msg_word[1]), .msg_vld(msg_vld[1]), .msg_rdy(msg_rdy[1]),
        .pix_rd_req(pix_rd_req[1]), .pix_rd_vld(pix_rd_vld[1]),
        .pix_r(pix_r[1]), .pix_g(pix_g[1]), .pix_b(pix_b[1]),
        .out_pix(out_pix[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]),
        .busy(busy[1]), .done(done[1])
    );

    always @(posedge clk) begin
        if (done[0]) done_cnt0 <= done_cnt0 + 1;
        if (done[1]) done_cnt1 <= done_cnt1 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int d, input logic [15:0] len);
        start[d]   = 1'b1;
        msg_len[d] = len;
        tick();
        start[d]   = 1'b0;
        msg_len[d] = 16'($urandom);
    endtask

    // FIFO model: data is driven only after the read handshake.
    task automatic feed(input int d, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [23:0] exp);
        int guard = 0;
        sb.push_back(exp);
        pix_r[d] = 8'($urandom);
        pix_g[d] = 8'($urandom);
        pix_b[d] = 8'($urandom);
        while (!pix_rd_req[d] && guard < 100) begin
            tick();
            guard++;
        end
        chk("req_wait", 32'(pix_rd_req[d]), 32'd1);
        pix_rd_vld[d] = 1'b1;
        tick();
        pix_rd_vld[d] = 1'b0;
        pix_r[d] = r;
        pix_g[d] = g;
        pix_b[d] = b;
    endtask

    // Runs one pixel from capture to output handshake; lat counts the
    // handshake cycle as cycle 1.
    task automatic run(input int d, input int stall_in, input int bp,
                       output int lat, output int hs, output int rdy_cyc, output logic dn);
        int          guard    = 0;
        int          stall    = stall_in;
        int          vld_lat  = 0;
        logic        stalling = 1'b0;
        logic        will_hs;
        logic [23:0] held;
        lat = 2; hs = 0; rdy_cyc = 0;
        while (!out_vld[d] && guard < 200) begin
            will_hs    = 1'b0;
            msg_vld[d] = 1'b0;
            if (msg_rdy[d]) rdy_cyc++;
            if (stall > 0 && (msg_rdy[d] || stalling)) begin
                stalling = 1'b1;
                chk("stall_rdy", 32'(msg_rdy[d]), 32'd1);
                stall--;
            end else if (msg_rdy[d] && wq.size() > 0) begin
                msg_vld[d]  = 1'b1;
                msg_word[d] = wq[0];
                will_hs     = 1'b1;
                if (stall_in > 0 && vld_lat == 0) vld_lat = lat;
            end
            tick();
            lat++;
            guard++;
            if (will_hs) begin
                void'(wq.pop_front());
                hs++;
            end
        end
        msg_vld[d] = 1'b0;
        chk("out_wait", 32'(out_vld[d]), 32'd1);
        if (stall_in > 0) stall_lat = lat - vld_lat + 1;
        held = out_pix[d];
        for (int i = 0; i < bp; i++) begin
            chk("bp_vld", 32'(out_vld[d]), 32'd1);
            chk("bp_pix", 32'(out_pix[d]), 32'(held));
            chk("bp_req", 32'(pix_rd_req[d]), 32'd0);
            tick();
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            chk("pixel", 32'(out_pix[d]), 32'(sb.pop_front()));
        end
        out_rdy[d] = 1'b1;
        tick();
        out_rdy[d] = 1'b0;
        dn = done[d];
        chk("req_after", 32'(pix_rd_req[d]), 32'd1);
    endtask

    // LSB_BITS=2 pixels against a bit-position model of the 40-bit message.
    task automatic run_lsb2(input int npix, output int hs_tot);
        logic [7:0]  ch[3];
        logic [23:0] px;
        int          lat, hs, rdy_cyc;
        logic        dn;
        hs_tot = 0;
        for (int k = 0; k < npix; k++) begin
            ch[0] = 8'h40 + 8'(k);
            ch[1] = 8'h80 + 8'(k);
            ch[2] = 8'hC0 + 8'(k);
            px = {ch[0], ch[1], ch[2]};
            for (int c = 0; c < 3; c++) begin
                if (mp < 40) begin
                    ch[c][1:0] = mbits[63-mp -: 2];
                    mp += 2;
                end
            end
            feed(1, px[23:16], px[15:8], px[7:0], {ch[0], ch[1], ch[2]});
            run(1, 0, 0, lat, hs, rdy_cyc, dn);
            hs_tot += hs;
            chk($sformatf("done_px%0d", k), 32'(dn), (k == 6) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int   lat, hs, rdy_cyc, hs_tot, dc;
        logic dn;

        // Reset with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start      = 2'($urandom);
            msg_vld    = 2'($urandom);
            pix_rd_vld = 2'($urandom);
            out_rdy    = 2'($urandom);
            msg_len    = 32'($urandom);
            msg_word   = {$urandom, $urandom};
            pix_r      = 16'($urandom);
            pix_g      = 16'($urandom);
            pix_b      = 16'($urandom);
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            chk("rst_req",  32'(pix_rd_req[d]), 32'd0);
            chk("rst_rdy",  32'(msg_rdy[d]),    32'd0);
            chk("rst_vld",  32'(out_vld[d]),    32'd0);
            chk("rst_pix",  32'(out_pix[d]),    32'd0);
            chk("rst_busy", 32'(busy[d]),       32'd0);
            chk("rst_done", 32'(done[d]),       32'd0);
        end
        start = '0; msg_vld = '0; pix_rd_vld = '0; out_rdy = '0;
        rst = 1'b1;
        tick();
        chk("rel_req0", 32'(pix_rd_req[0]), 32'd1);
        chk("rel_req1", 32'(pix_rd_req[1]), 32'd1);

        // Pass-through with nothing armed.
        feed(0, 8'hFF, 8'h00, 8'h7F, 24'hFF007F);
        run(0, 0, 0, lat, hs, rdy_cyc, dn);
        chk("pt_lat", 32'(lat), 32'd6);
        chk("pt_rdy", 32'(rdy_cyc), 32'd0);
        chk("pt_done", 32'(dn), 32'd0);

        // LSB_BITS=1, 6-bit message; a second start while busy is ignored.
        wq.delete();
        wq.push_back(32'hA0000000);
        arm(0, 16'd6);
        chk("m1_busy", 32'(busy[0]), 32'd1);
        arm(0, 16'd100);
        feed(0, 8'h10, 8'h11, 8'h12, 24'h111013);
        run(0, 0, 0, lat, hs, rdy_cyc, dn);
        chk("m1_lat", 32'(lat), 32'd7);
        chk("m1_hs", 32'(hs), 32'd1);
        chk("m1_done_a", 32'(dn), 32'd0);
        feed(0, 8'h20, 8'h21, 8'h22, 24'h202022);
        run(0, 0, 0, lat, hs, rdy_cyc, dn);
        chk("m1_done_b", 32'(dn), 32'd1);
        chk("m1_busy_clr", 32'(busy[0]), 32'd0);
        tick();
        chk("m1_done_pulse", 32'(done[0]), 32'd0);
        feed(0, 8'h33, 8'h33, 8'h33, 24'h333333);
        run(0, 0, 0, lat, hs, rdy_cyc, dn);
        chk("m1_tail_rdy", 32'(rdy_cyc), 32'd0);
        chk("m1_done_cnt", 32'(done_cnt0), 32'd1);

        // Message stall in S_R followed by output backpressure.
        wq.delete();
        wq.push_back(32'hFFFFFFFF);
        arm(0, 16'd3);
        feed(0, 8'h01, 8'h02, 8'h03, 24'h010303);
        run(0, 10, 5, lat, hs, rdy_cyc, dn);
        chk("st_lat", 32'(stall_lat), 32'd5);
        chk("st_rdy_cyc", 32'(rdy_cyc), 32'd11);
        chk("st_done", 32'(dn), 32'd1);

        // LSB_BITS=2: a length that rounds to zero completes at once.
        start[1] = 1'b1; msg_len[1] = 16'd1;
        tick();
        start[1] = 1'b0;
        chk("z_done", 32'(done[1]), 32'd1);
        chk("z_busy", 32'(busy[1]), 32'd0);
        tick();
        chk("z_done_clr", 32'(done[1]), 32'd0);
        chk("z_busy_clr", 32'(busy[1]), 32'd0);

        // 40-bit message across a word boundary.
        mbits = {32'hDEADBEEF, 32'h12345678};
        mp = 0;
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h12345678);
        arm(1, 16'd40);
        run_lsb2(8, hs_tot);
        chk("wb_hs", 32'(hs_tot), 32'd2);
        chk("wb_busy", 32'(busy[1]), 32'd0);

        // Same message, reset during the 4th pixel.
        mp = 0;
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h12345678);
        arm(1, 16'd40);
        run_lsb2(3, hs_tot);
        dc = done_cnt1;
        feed(1, 8'h55, 8'h66, 8'h77, 24'h000000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mr_busy", 32'(busy[1]), 32'd0);
        chk("mr_vld", 32'(out_vld[1]), 32'd0);
        chk("mr_rdy", 32'(msg_rdy[1]), 32'd0);
        chk("mr_pix", 32'(out_pix[1]), 32'd0);
        sb.delete();
        wq.delete();
        rst = 1'b1;
        tick();
        chk("mr_req", 32'(pix_rd_req[1]), 32'd1);
        chk("mr_no_done", 32'(done_cnt1), 32'(dc));

        // Clean restart: 7 bits round down to 6, one fully modified pixel.
        wq.push_back(32'hC0FFEE00);
        arm(1, 16'd7);
        chk("rs_busy", 32'(busy[1]), 32'd1);
        feed(1, 8'h40, 8'h80, 8'hC0, 24'h4380C0);
        run(1, 0, 0, lat, hs, rdy_cyc, dn);
        chk("rs_done", 32'(dn), 32'd1);
        chk("rs_busy_clr", 32'(busy[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
